// File: rtl/mem_wait_ctrl.sv
// mem_wait_ctrl: sits between the Core data port and a synchronous RAM.
// It latches one Core request and inserts READ_WAIT or WRITE_WAIT idle
// cycles. It then issues the request to RAM exactly once and, for reads,
// captures the RAM data the following cycle. The Core stays stalled from
// acceptance until the DONE cycle.
module mem_wait_ctrl #(
    parameter int READ_WAIT  = 2,
    parameter int WRITE_WAIT = 1,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_en,
    input  logic [3:0]  cpu_write_en,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_write_data,
    output logic [31:0] cpu_read_data,
    output logic        stall,
    output logic        mem_en,
    output logic [3:0]  mem_write_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ISSUE,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] RD_CNT  = CNT_W'(READ_WAIT);
    localparam logic [CNT_W-1:0] WR_CNT  = CNT_W'(WRITE_WAIT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        we_q, we_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [CNT_W-1:0]  wait_load;
    logic              stall_c;

    // State and request registers; reset clears everything so a write cut
    // short by reset can never reach RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state, request latching and RAM strobe generation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        rdata_d      = rdata_q;
        stall_c      = 1'b0;
        mem_en       = 1'b0;
        mem_write_en = 4'b0000;
        wait_load    = (cpu_write_en != 4'b0000) ? WR_CNT : RD_CNT;

        case (state_q)
            S_IDLE: begin
                // The Core must see the stall in the same cycle it asserts
                // the request, so this path is combinational from cpu_en.
                stall_c = cpu_en;
                if (cpu_en) begin
                    addr_d  = cpu_addr;
                    wdata_d = cpu_write_data;
                    we_d    = cpu_write_en;
                    cnt_d   = wait_load;
                    state_d = (wait_load != '0) ? S_WAIT : S_ISSUE;
                end
            end
            S_WAIT: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q - CNT_ONE;
                // A count of 1 is the last wait cycle; <= guards an
                // unreachable zero so the FSM can never lock up here.
                if (cnt_q <= CNT_ONE) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                stall_c      = 1'b1;
                mem_en       = 1'b1;
                mem_write_en = we_q;
                state_d      = (we_q != 4'b0000) ? S_DONE : S_CAPTURE;
            end
            S_CAPTURE: begin
                // RAM read data is valid one cycle after the issue edge.
                stall_c = 1'b1;
                rdata_d = mem_read_data;
                state_d = S_DONE;
            end
            S_DONE: begin
                // Core advances at this edge; its still-held request is
                // deliberately not looked at here.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Reset forces IDLE asynchronously, but IDLE stall follows cpu_en, so
    // reset must also mask it for stall to drop without a clock edge.
    assign stall          = stall_c & ~rst;
    assign mem_addr       = addr_q;
    assign mem_write_data = wdata_q;
    assign cpu_read_data  = rdata_q;

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// Directed bench for mem_wait_ctrl. Instance A uses the default waits
// (read 2, write 1); instance B has zero waits. Each instance drives its
// own small synchronous RAM model.
module tb_mem_wait_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    logic sel = 1'b0;

    // instance A signals
    logic        en_a = 1'b0;
    logic [3:0]  we_a = '0;
    logic [31:0] ad_a = '0, wd_a = '0, rd_a, mrd_a, maddr_a, mwd_a;
    logic        stall_a, men_a;
    logic [3:0]  mwe_a;
    // instance B signals
    logic        en_b = 1'b0;
    logic [3:0]  we_b = '0;
    logic [31:0] ad_b = '0, wd_b = '0, rd_b, mrd_b, maddr_b, mwd_b;
    logic        stall_b, men_b;
    logic [3:0]  mwe_b;

    logic [31:0] ram_a [0:63];
    logic [31:0] ram_b [0:63];

    mem_wait_ctrl #(.READ_WAIT(2), .WRITE_WAIT(1), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .cpu_en(en_a), .cpu_write_en(we_a),
        .cpu_addr(ad_a), .cpu_write_data(wd_a), .cpu_read_data(rd_a),
        .stall(stall_a), .mem_en(men_a), .mem_write_en(mwe_a),
        .mem_addr(maddr_a), .mem_write_data(mwd_a), .mem_read_data(mrd_a));

    mem_wait_ctrl #(.READ_WAIT(0), .WRITE_WAIT(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .cpu_en(en_b), .cpu_write_en(we_b),
        .cpu_addr(ad_b), .cpu_write_data(wd_b), .cpu_read_data(rd_b),
        .stall(stall_b), .mem_en(men_b), .mem_write_en(mwe_b),
        .mem_addr(maddr_b), .mem_write_data(mwd_b), .mem_read_data(mrd_b));

    // Synchronous RAM models: byte-masked write, registered read.
    always @(posedge clk) begin
        if (men_a) begin
            if (mwe_a != 4'b0000) begin
                for (int b = 0; b < 4; b++)
                    if (mwe_a[b]) ram_a[maddr_a[7:2]][8*b +: 8] <= mwd_a[8*b +: 8];
            end else begin
                mrd_a <= ram_a[maddr_a[7:2]];
            end
        end
    end

    always @(posedge clk) begin
        if (men_b) begin
            if (mwe_b != 4'b0000) begin
                for (int b = 0; b < 4; b++)
                    if (mwe_b[b]) ram_b[maddr_b[7:2]][8*b +: 8] <= mwd_b[8*b +: 8];
            end else begin
                mrd_b <= ram_b[maddr_b[7:2]];
            end
        end
    end

    wire        s_stall = sel ? stall_b : stall_a;
    wire        s_men   = sel ? men_b   : men_a;
    wire [3:0]  s_mwe   = sel ? mwe_b   : mwe_a;
    wire [31:0] s_maddr = sel ? maddr_b : maddr_a;
    wire [31:0] s_mwd   = sel ? mwd_b   : mwd_a;
    wire [31:0] s_rd    = sel ? rd_b    : rd_a;

    task automatic drive(input logic en, input logic [3:0] we,
                         input logic [31:0] ad, input logic [31:0] wd);
        if (sel) begin en_b = en; we_b = we; ad_b = ad; wd_b = wd; end
        else     begin en_a = en; we_a = we; ad_a = ad; wd_a = wd; end
    endtask

    // One Core transaction, started at the next negedge, sampled 1 ns
    // after each negedge until the DONE cycle (stall low).
    task automatic run_txn(input string nm, input logic [3:0] we,
                           input logic [31:0] ad, input logic [31:0] wd,
                           input int exp_stall, input int exp_pos,
                           input logic [31:0] exp_rd);
        int n = 0, pulses = 0, pos = 0;
        bit done = 0, rd_chg = 0;
        logic [3:0]  we_s = '0;
        logic [31:0] ad_s = '0, wd_s = '0, rd0, rd_done = '0;
        @(negedge clk);
        drive(1'b1, we, ad, wd);
        #1;
        rd0 = s_rd;
        for (int i = 0; i < 30 && !done; i++) begin
            if (s_men) begin
                pulses++;
                pos = n + 1;
                we_s = s_mwe; ad_s = s_maddr; wd_s = s_mwd;
            end
            if (s_stall) begin
                n++;
                if (s_rd !== rd0) rd_chg = 1;
            end else begin
                done = 1;
                rd_done = s_rd;
            end
            if (!done) begin
                @(negedge clk);
                #1;
            end
        end
        vecs++; if (!done) begin errs++; $display("FAIL %s_timeout: no DONE cycle within 30 cycles", nm); end
        vecs++; if (n !== exp_stall) begin errs++; $display("FAIL %s_stall_len: got %0d want %0d", nm, n, exp_stall); end
        vecs++; if (pulses !== 1) begin errs++; $display("FAIL %s_mem_en_pulses: got %0d want 1", nm, pulses); end
        vecs++; if (pos !== exp_pos) begin errs++; $display("FAIL %s_mem_en_cycle: got %0d want %0d", nm, pos, exp_pos); end
        vecs++; if (we_s !== we) begin errs++; $display("FAIL %s_mem_we: got %h want %h", nm, we_s, we); end
        vecs++; if (ad_s !== ad) begin errs++; $display("FAIL %s_mem_addr: got %h want %h", nm, ad_s, ad); end
        vecs++; if (wd_s !== wd) begin errs++; $display("FAIL %s_mem_wdata: got %h want %h", nm, wd_s, wd); end
        vecs++; if (rd_chg) begin errs++; $display("FAIL %s_rd_stable: cpu_read_data changed during stall, start %h", nm, rd0); end
        vecs++; if (rd_done !== exp_rd) begin errs++; $display("FAIL %s_rdata: got %h want %h", nm, rd_done, exp_rd); end
    endtask

    // Drop the request and confirm the block stays quiet.
    task automatic idle_check(input string nm, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            drive(1'b0, 4'b0000, 32'h0, 32'h0);
            #1;
            vecs++;
            if (s_stall !== 1'b0 || s_men !== 1'b0) begin
                errs++;
                $display("FAIL %s_idle: stall=%b mem_en=%b want 0 0", nm, s_stall, s_men);
            end
        end
    endtask

    task automatic test_reset;
        #2;
        vecs++;
        if ({stall_a, men_a, mwe_a, maddr_a, mwd_a, rd_a} !== '0) begin
            errs++; $display("FAIL reset_a: outputs not all zero");
        end
        vecs++;
        if ({stall_b, men_b, mwe_b, maddr_b, mwd_b, rd_b} !== '0) begin
            errs++; $display("FAIL reset_b: outputs not all zero");
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_idle;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            vecs++;
            if ({stall_a, men_a, mwe_a, maddr_a, mwd_a, rd_a,
                 stall_b, men_b, mwe_b, maddr_b, mwd_b, rd_b} !== '0) begin
                errs++; $display("FAIL idle_outputs: nonzero output in idle cycle %0d", i);
            end
        end
    endtask

    task automatic test_read;
        sel = 1'b0;
        run_txn("read1", 4'b0000, 32'h10, 32'h0, 5, 4, 32'hDEADBEEF);
        idle_check("read1", 3);
    endtask

    task automatic test_write;
        sel = 1'b0;
        run_txn("wr_full", 4'b1111, 32'h20, 32'h12345678, 3, 3, 32'hDEADBEEF);
        idle_check("wr_full", 2);
        run_txn("rd_full", 4'b0000, 32'h20, 32'h0, 5, 4, 32'h12345678);
        idle_check("rd_full", 2);
    endtask

    task automatic test_byte_write;
        sel = 1'b0;
        run_txn("wr_byte", 4'b0001, 32'h20, 32'h000000AB, 3, 3, 32'h12345678);
        run_txn("rd_byte", 4'b0000, 32'h20, 32'h0, 5, 4, 32'h123456AB);
        idle_check("rd_byte", 2);
    endtask

    task automatic test_back_to_back;
        sel = 1'b1;
        run_txn("b2b_rd0", 4'b0000, 32'h40, 32'h0, 3, 2, 32'h0BADF00D);
        run_txn("b2b_wr",  4'b1111, 32'h44, 32'h55AA55AA, 2, 2, 32'h0BADF00D);
        run_txn("b2b_rd1", 4'b0000, 32'h44, 32'h0, 3, 2, 32'h55AA55AA);
        idle_check("b2b", 2);
        vecs++;
        if (ram_b[17] !== 32'h55AA55AA) begin
            errs++; $display("FAIL b2b_ram: got %h want 55aa55aa", ram_b[17]);
        end
        sel = 1'b0;
    endtask

    task automatic test_reset_mid_write;
        sel = 1'b0;
        @(negedge clk);
        drive(1'b1, 4'b1111, 32'h30, 32'hCAFEF00D);
        @(posedge clk);          // IDLE -> WAIT
        @(posedge clk);          // WAIT -> ISSUE
        #1;
        vecs++;
        if (men_a !== 1'b1) begin
            errs++; $display("FAIL rstmid_issue: mem_en=%b want 1", men_a);
        end
        rst = 1'b1;
        #1;
        vecs++;
        if (stall_a !== 1'b0 || men_a !== 1'b0) begin
            errs++; $display("FAIL rstmid_drop: stall=%b mem_en=%b want 0 0", stall_a, men_a);
        end
        vecs++;
        if (rd_a !== 32'h0) begin
            errs++; $display("FAIL rstmid_rdata: got %h want 0", rd_a);
        end
        @(negedge clk);
        drive(1'b0, 4'b0000, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        vecs++;
        if (ram_a[12] !== 32'h11111111) begin
            errs++; $display("FAIL rstmid_ram: got %h want 11111111", ram_a[12]);
        end
        run_txn("rstmid_rd", 4'b0000, 32'h30, 32'h0, 5, 4, 32'h11111111);
        idle_check("rstmid_rd", 2);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            ram_a[i] = 32'h0;
            ram_b[i] = 32'h0;
        end
        ram_a[4]  = 32'hDEADBEEF;   // 0x10
        ram_a[12] = 32'h11111111;   // 0x30
        ram_b[16] = 32'h0BADF00D;   // 0x40
        mrd_a = '0;
        mrd_b = '0;
        test_reset();
        test_idle();
        test_read();
        test_write();
        test_byte_write();
        test_back_to_back();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/mem_wait_ctrl.md
Name: mem_wait_ctrl

Overview:
- Sits between the Core data-memory port and RAM, on the core's `stall` input path.
- Latches each Core RAM request and inserts programmable wait states, then issues the access to RAM exactly once.
- For reads, captures the synchronous RAM read data; holds Core via `stall` for the whole transaction.
- Lets the pipeline be exercised against slow memory without changing RAM.

Parameters:
- READ_WAIT, 2: wait cycles inserted before a read is issued to RAM (0 allowed).
- WRITE_WAIT, 1: wait cycles inserted before a write is issued to RAM (0 allowed).
- CNT_W, 4: wait-counter width. READ_WAIT and WRITE_WAIT must each be < 2^CNT_W.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_en  in  1  Core RAM request valid.
- cpu_write_en  in  4  Core byte write enables; nonzero = write, zero = read.
- cpu_addr  in  32  Core byte address.
- cpu_write_data  in  32  Core store data.
- cpu_read_data  out  32  load data returned to Core.
- stall  out  1  pipeline stall to Core.
- mem_en  out  1  RAM enable.
- mem_write_en  out  4  RAM byte write enables.
- mem_addr  out  32  RAM address.
- mem_write_data  out  32  RAM write data.
- mem_read_data  in  32  RAM read data, valid the cycle after a read is issued.

Behaviour:
- Reset (async, while rst=1):
  - state=IDLE; counter=0.
  - Request latches (addr, wdata, we) = 0; rdata_q = 0.
  - Outputs: stall=0, mem_en=0, mem_write_en=0, mem_addr=0, mem_write_data=0, cpu_read_data=0.
- Core contract: cpu_en, cpu_write_en, cpu_addr and cpu_write_data are held stable while stall=1 and through the DONE cycle.
- States: IDLE, WAIT, ISSUE, CAPTURE, DONE.
  - IDLE: stall = cpu_en (combinational).
    - If cpu_en=1, latch the request; counter <= READ_WAIT (we==0) or WRITE_WAIT (we!=0).
    - Next state is WAIT if that value > 0, else ISSUE.
    - If cpu_en=0, stay in IDLE.
  - WAIT: stall=1; counter decrements each cycle; go to ISSUE when counter==1. Exactly N cycles are spent in WAIT.
  - ISSUE: stall=1.
    - mem_en=1; mem_write_en=latched we; mem_addr and mem_write_data = latched values.
    - Write: commits at this edge; next state DONE.
    - Read: next state CAPTURE.
  - CAPTURE (reads only): stall=1; rdata_q <= mem_read_data at end of cycle; next state DONE.
  - DONE: stall=0; the Core advances at this edge. Always return to IDLE; the request still held in this cycle is never re-accepted.
- mem_en and mem_write_en are 0 in every state except ISSUE.
- mem_addr and mem_write_data hold their latched values outside ISSUE.
- cpu_read_data = rdata_q at all times. It changes only at the CAPTURE edge; writes leave it unchanged.
- stall-cycle counts:
  - Read: READ_WAIT+3 cycles (IDLE, WAIT×N, ISSUE, CAPTURE), then one DONE cycle.
  - Write: WRITE_WAIT+2 cycles, then one DONE cycle.
- Back-to-back requests: at least one IDLE cycle after DONE. A new request is accepted in the first IDLE cycle where cpu_en=1.
- Reset mid-operation:
  - Immediate return to IDLE; stall and mem_en drop without waiting for a clock edge.
  - A write whose ISSUE cycle is cut by reset before the rising edge is not committed.
  - rdata_q is cleared.
- cpu_en=0 while stall=1 (contract violation): ignored; the latched request completes normally.
- No address alignment or byte-enable legality checks; the RAM owns those.

Test Plan:
1. READ_WAIT=2, RAM word 0x10 preloaded with 0xDEADBEEF; Core reads 0x10 -> stall high 5 cycles; mem_en high exactly 1 cycle, in the 4th, with mem_write_en=0; DONE cycle shows cpu_read_data=0xDEADBEEF, stall=0.
2. WRITE_WAIT=1; Core writes 0x12345678 to 0x20 with we=4'b1111 -> stall high 3 cycles; single mem_en pulse with mem_write_en=4'b1111; a subsequent read of 0x20 returns 0x12345678.
3. Byte write of 0x000000AB to 0x20 with we=4'b0001, then read 0x20 -> 0x123456AB; cpu_read_data unchanged between the write's DONE and the read's CAPTURE.
4. READ_WAIT=0, WRITE_WAIT=0; read, write, read back-to-back -> stall lengths 3, 2, 3; exactly one IDLE cycle between each DONE and the next acceptance; 3 mem_en pulses total.
5. Assert rst 1 ns after the write ISSUE cycle begins (before its edge) -> stall and mem_en fall immediately; RAM location is unchanged; cpu_read_data=0; after release, a new read is accepted normally.
6. cpu_en held 0 for 20 cycles after reset -> stall=0, mem_en=0, all outputs 0 throughout.
